// File: rtl/tl_ul_master_q_pkg.sv
// Shared TileLink-UL definitions for the queued master: channel opcodes,
// the request-entry layout and the opcode selection rule for CPU requests.
package tl_ul_pkg;

    typedef enum logic [3:0] {
        PUT_FULL    = 4'h0,
        PUT_PARTIAL = 4'h1,
        GET         = 4'h4
    } a_opcode_e;

    typedef enum logic [3:0] {
        ACK      = 4'h0,
        ACK_DATA = 4'h1
    } d_opcode_e;

    localparam int TL_AW = 4;
    localparam int TL_DW = 32;
    localparam int TL_MW = TL_DW / 8;

    // Request-entry layout at the default bus widths; the master builds a
    // width-parameterised struct with the same field order.
    typedef struct packed {
        a_opcode_e          opcode;
        logic [TL_MW-1:0]   mask;
        logic [TL_AW-1:0]   addr;
        logic [TL_DW-1:0]   data;
    } req_entry_t;

    // A write with every byte enabled is a full put; any other write
    // (including an empty mask) is partial; a read is a Get.
    function automatic a_opcode_e req_opcode(input logic is_write, input logic full_mask);
        a_opcode_e op;
        if (is_write) begin
            if (full_mask) begin
                op = PUT_FULL;
            end else begin
                op = PUT_PARTIAL;
            end
        end else begin
            op = GET;
        end
        return op;
    endfunction

endpackage

// File: rtl/tl_ul_master_q_if.sv
// TileLink-UL A/D channel pair between the queued master and the bus.
interface tl_ul_master_q_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    logic          a_valid;
    logic          a_ready;
    logic [3:0]    a_opcode;
    logic [MW-1:0] a_mask;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_data;

    logic          d_ready;
    logic          d_valid;
    logic [3:0]    d_opcode;
    logic          d_error;
    logic [DW-1:0] d_data;

    modport master (
        output a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_error, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_error, d_data
    );
endinterface

// File: rtl/tl_ul_master_q_fifo.sv
// Synchronous first-word-fall-through FIFO. The head reads as zero when the
// FIFO is empty; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign empty = (count_r == '0);
    assign full  = (count_r == DEPTH_C);
    assign head  = empty ? '0 : mem_r[rd_ptr_r];

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/tl_ul_master_q.sv
// Queued TileLink-UL master: buffers CPU requests, issues them on the A
// channel with a cap on outstanding transactions, and routes D-channel
// responses back to the CPU in order.
module tl_ul_master_q
    import tl_ul_pkg::*;
#(
    parameter int AW      = 4,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_wr,
    input  logic            cpu_rd,
    input  logic [DW/8-1:0] cpu_byte,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic            cpu_ready,
    output logic            cpu_rdata_v,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_wack,
    output logic            cpu_err,
    output logic            trans_over,
    tl_ul_master_q_if.master tl
);
    localparam int MW = DW / 8;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

    typedef struct packed {
        logic [3:0]    opcode;
        logic [MW-1:0] mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    req_t          req_in_s;
    req_t          req_head_s;
    logic          req_full_s;
    logic          req_empty_s;
    logic          accept_s;
    logic          a_valid_s;
    logic          a_hs_s;
    logic          d_hs_s;
    logic          d_ok_s;
    logic          head_is_read_s;
    logic          type_full_s;
    logic          type_empty_s;
    logic          type_head_s;
    logic          rsp_err_s;
    logic [OW-1:0] outstanding_r;
    logic          d_ready_r;
    logic          rdata_v_r;
    logic          wack_r;
    logic          err_r;
    logic [DW-1:0] rdata_r;

    // Build the request entry; write wins when both strobes are high.
    always_comb begin
        req_in_s = '0;
        if (cpu_wr) begin
            req_in_s.opcode = req_opcode(1'b1, &cpu_byte);
            req_in_s.mask   = cpu_byte;
            req_in_s.addr   = cpu_addr;
            req_in_s.data   = cpu_wdata;
        end else begin
            req_in_s.opcode = req_opcode(1'b0, 1'b0);
            req_in_s.mask   = cpu_byte;
            req_in_s.addr   = cpu_addr;
            req_in_s.data   = '0;
        end
    end

    // Handshake qualification; the type-FIFO flags track the counter and
    // only back it up.
    always_comb begin
        accept_s       = (cpu_wr | cpu_rd) & ~req_full_s;
        a_valid_s      = ~req_empty_s & (outstanding_r < MAX_OUT_C) & ~type_full_s;
        a_hs_s         = a_valid_s & tl.a_ready;
        d_hs_s         = tl.d_valid & d_ready_r;
        d_ok_s         = d_hs_s & (outstanding_r != '0) & ~type_empty_s;
        head_is_read_s = (req_head_s.opcode == GET);
    end

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .pop   (a_hs_s),
        .din   (req_in_s),
        .full  (req_full_s),
        .empty (req_empty_s),
        .head  (req_head_s)
    );

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUT)
    ) u_type_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (a_hs_s),
        .pop   (d_ok_s),
        .din   (head_is_read_s),
        .full  (type_full_s),
        .empty (type_empty_s),
        .head  (type_head_s)
    );

    // Response error: bad status or opcode on an expected response, or any
    // response arriving with nothing outstanding.
    always_comb begin
        rsp_err_s = 1'b0;
        if (d_ok_s) begin
            if (type_head_s) begin
                rsp_err_s = tl.d_error | (tl.d_opcode != ACK_DATA);
            end else begin
                rsp_err_s = tl.d_error | (tl.d_opcode != ACK);
            end
        end else begin
            rsp_err_s = d_hs_s;
        end
    end

    // Outstanding count, D-ready and registered CPU response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
            d_ready_r     <= 1'b0;
            rdata_v_r     <= 1'b0;
            wack_r        <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= '0;
        end else begin
            d_ready_r <= 1'b1;
            case ({a_hs_s, d_ok_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            rdata_v_r <= d_ok_s & type_head_s;
            wack_r    <= d_ok_s & ~type_head_s;
            err_r     <= rsp_err_s;
            if (d_ok_s & type_head_s) begin
                rdata_r <= tl.d_data;
            end
        end
    end

    assign cpu_ready    = ~req_full_s;
    assign cpu_rdata_v  = rdata_v_r;
    assign cpu_rdata    = rdata_r;
    assign cpu_wack     = wack_r;
    assign cpu_err      = err_r;
    assign trans_over   = req_empty_s & (outstanding_r == '0);

    assign tl.a_valid   = a_valid_s;
    assign tl.a_opcode  = req_head_s.opcode;
    assign tl.a_mask    = req_head_s.mask;
    assign tl.a_address = req_head_s.addr;
    assign tl.a_data    = req_head_s.data;
    assign tl.d_ready   = d_ready_r;
endmodule

// File: tb/tb_tl_ul_master_q.sv
// Directed self-checking bench for the queued TileLink-UL master.
module tb_tl_ul_master_q;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr, cpu_rd;
    logic [3:0]  cpu_byte;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_rdata_v, cpu_wack, cpu_err, trans_over;
    logic [31:0] cpu_rdata;
    int          checks = 0;
    int          errors = 0;

    tl_ul_master_q_if #(.AW(4), .DW(32)) tl ();

    tl_ul_master_q #(.AW(4), .DW(32), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata_v(cpu_rdata_v), .cpu_rdata(cpu_rdata),
        .cpu_wack(cpu_wack), .cpu_err(cpu_err), .trans_over(trans_over),
        .tl(tl.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (tl.a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %h want 0", tl.a_valid); end
        checks++; if ({tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data} !== 44'h0) begin errors++; $display("FAIL rst_a_fields got %h want 0", {tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data}); end
        checks++; if (tl.d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %h want 0", tl.d_ready); end
        checks++; if ({cpu_rdata_v, cpu_wack, cpu_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {cpu_rdata_v, cpu_wack, cpu_err}); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
        checks++; if ({cpu_ready, trans_over} !== 2'b11) begin errors++; $display("FAIL rst_ready_over got %b want 11", {cpu_ready, trans_over}); end
        rst = 1'b0;
        tick();
        checks++; if (tl.d_ready !== 1'b1) begin errors++; $display("FAIL d_ready_after_rst got %h want 1", tl.d_ready); end
    endtask

    task automatic test_write_full();
        tl.a_ready = 1'b1;
        cpu_wr = 1'b1; cpu_addr = 4'h3; cpu_byte = 4'hF; cpu_wdata = 32'hDEADBEEF;
        tick();
        cpu_wr = 1'b0;
        checks++; if (trans_over !== 1'b0) begin errors++; $display("FAIL wf_over_fall got %h want 0", trans_over); end
        checks++; if ({tl.a_valid, tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data} !== {1'b1, 4'h0, 4'hF, 4'h3, 32'hDEADBEEF})
            begin errors++; $display("FAIL wf_a_beat got %h want %h", {tl.a_valid, tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data}, {1'b1, 4'h0, 4'hF, 4'h3, 32'hDEADBEEF}); end
        tick();
        tl.a_ready = 1'b0;
        checks++; if (tl.a_valid !== 1'b0) begin errors++; $display("FAIL wf_a_done got %h want 0", tl.a_valid); end
        tl.d_valid = 1'b1; tl.d_opcode = 4'h0;
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({cpu_wack, cpu_rdata_v, cpu_err, trans_over} !== 4'b1001) begin errors++; $display("FAIL wf_wack got %b want 1001", {cpu_wack, cpu_rdata_v, cpu_err, trans_over}); end
        tick();
        checks++; if (cpu_wack !== 1'b0) begin errors++; $display("FAIL wf_wack_pulse got %h want 0", cpu_wack); end
    endtask

    task automatic test_partial_read();
        tl.a_ready = 1'b0;
        cpu_wr = 1'b1; cpu_byte = 4'h5; cpu_addr = 4'h1; cpu_wdata = 32'hAABBCCDD;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'h3;
        checks++; if ({tl.a_valid, tl.a_opcode, tl.a_mask} !== {1'b1, 4'h1, 4'h5}) begin errors++; $display("FAIL pr_partial got %h want %h", {tl.a_valid, tl.a_opcode, tl.a_mask}, {1'b1, 4'h1, 4'h5}); end
        tick();
        cpu_rd = 1'b0; tl.a_ready = 1'b1;
        tick();
        checks++; if ({tl.a_valid, tl.a_opcode, tl.a_address, tl.a_data} !== {1'b1, 4'h4, 4'h3, 32'h0}) begin errors++; $display("FAIL pr_get got %h want %h", {tl.a_valid, tl.a_opcode, tl.a_address, tl.a_data}, {1'b1, 4'h4, 4'h3, 32'h0}); end
        tick();
        tl.a_ready = 1'b0;
        tl.d_valid = 1'b1; tl.d_opcode = 4'h0;
        tick();
        checks++; if ({cpu_wack, cpu_rdata_v, cpu_err} !== 3'b100) begin errors++; $display("FAIL pr_wack got %b want 100", {cpu_wack, cpu_rdata_v, cpu_err}); end
        tl.d_opcode = 4'h1; tl.d_data = 32'h12345678;
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({cpu_wack, cpu_rdata_v, cpu_err} !== 3'b010) begin errors++; $display("FAIL pr_rdata_v got %b want 010", {cpu_wack, cpu_rdata_v, cpu_err}); end
        checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL pr_rdata got %h want 12345678", cpu_rdata); end
        tick();
        checks++; if ({cpu_rdata_v, trans_over, cpu_rdata} !== {1'b0, 1'b1, 32'h12345678}) begin errors++; $display("FAIL pr_hold got %h want %h", {cpu_rdata_v, trans_over, cpu_rdata}, {1'b0, 1'b1, 32'h12345678}); end
    endtask

    task automatic test_stall();
        int bad;
        tl.a_ready = 1'b0;
        cpu_byte = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'b1; cpu_addr = 4'(i + 1); cpu_wdata = 32'(i + 1);
            tick();
        end
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL st_ready3 got %h want 1", cpu_ready); end
        cpu_addr = 4'h4; cpu_wdata = 32'h4;
        tick();
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL st_ready4 got %h want 0", cpu_ready); end
        cpu_addr = 4'h5; cpu_wdata = 32'h5;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({cpu_ready, tl.a_valid, tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data} !== {1'b0, 1'b1, 4'h0, 4'hF, 4'h1, 32'h1}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL st_stable got %0d unstable cycles want 0", bad); end
        cpu_wr = 1'b0; tl.a_ready = 1'b1;
        tick();
        checks++; if ({cpu_ready, tl.a_address} !== {1'b1, 4'h2}) begin errors++; $display("FAIL st_pop1 got %h want %h", {cpu_ready, tl.a_address}, {1'b1, 4'h2}); end
        tick();
        checks++; if ({tl.a_valid, tl.a_address} !== {1'b0, 4'h3}) begin errors++; $display("FAIL st_limit got %h want %h", {tl.a_valid, tl.a_address}, {1'b0, 4'h3}); end
        tl.d_valid = 1'b1; tl.d_opcode = 4'h0;
        tick();
        checks++; if ({cpu_wack, tl.a_valid, tl.a_address} !== {1'b1, 1'b1, 4'h3}) begin errors++; $display("FAIL st_resume got %h want %h", {cpu_wack, tl.a_valid, tl.a_address}, {1'b1, 1'b1, 4'h3}); end
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({cpu_wack, tl.a_valid, tl.a_address} !== {1'b1, 1'b1, 4'h4}) begin errors++; $display("FAIL st_b2b got %h want %h", {cpu_wack, tl.a_valid, tl.a_address}, {1'b1, 1'b1, 4'h4}); end
        tick();
        checks++; if ({cpu_wack, tl.a_valid, tl.a_address, trans_over} !== {1'b0, 1'b0, 4'h0, 1'b0}) begin errors++; $display("FAIL st_drained got %h want %h", {cpu_wack, tl.a_valid, tl.a_address, trans_over}, {1'b0, 1'b0, 4'h0, 1'b0}); end
        tl.a_ready = 1'b0;
        tl.d_valid = 1'b1;
        tick();
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({trans_over, cpu_err, cpu_wack} !== 3'b101) begin errors++; $display("FAIL st_done got %b want 101", {trans_over, cpu_err, cpu_wack}); end
        tick();
    endtask

    task automatic test_max_out();
        int hs, wcnt, ecnt;
        hs = 0;
        tl.a_ready = 1'b1; cpu_byte = 4'hF;
        for (int i = 0; i < 10; i++) begin
            cpu_wr = (i < 4); cpu_addr = 4'(i); cpu_wdata = 32'(i);
            if (tl.a_valid && tl.a_ready) hs++;
            tick();
        end
        cpu_wr = 1'b0;
        checks++; if (hs !== 2) begin errors++; $display("FAIL mo_handshakes got %0d want 2", hs); end
        checks++; if ({tl.a_valid, cpu_ready, trans_over} !== 3'b010) begin errors++; $display("FAIL mo_blocked got %b want 010", {tl.a_valid, cpu_ready, trans_over}); end
        tl.d_valid = 1'b1; tl.d_opcode = 4'h0;
        tick();
        checks++; if (tl.a_valid !== 1'b1) begin errors++; $display("FAIL mo_unblock got %h want 1", tl.a_valid); end
        wcnt = int'(cpu_wack); ecnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_wack) wcnt++;
            if (cpu_err) ecnt++;
        end
        tl.d_valid = 1'b0; tl.a_ready = 1'b0;
        tick();
        checks++; if (wcnt !== 4) begin errors++; $display("FAIL mo_wacks got %0d want 4", wcnt); end
        checks++; if ({ecnt, trans_over} !== {32'd0, 1'b1}) begin errors++; $display("FAIL mo_end got err=%0d over=%h want err=0 over=1", ecnt, trans_over); end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 2; k++) begin
            tl.a_ready = 1'b1;
            cpu_rd = 1'b1; cpu_addr = 4'h2; cpu_byte = 4'hF;
            tick();
            cpu_rd = 1'b0;
            tick();
            tl.a_ready = 1'b0;
            tl.d_valid = 1'b1;
            tl.d_opcode = (k == 0) ? 4'h0 : 4'h1;
            tl.d_error  = (k == 1);
            tl.d_data   = (k == 0) ? 32'h55 : 32'h66;
            tick();
            tl.d_valid = 1'b0; tl.d_error = 1'b0;
            checks++; if ({cpu_rdata_v, cpu_err, cpu_wack} !== 3'b110) begin errors++; $display("FAIL er_case%0d got %b want 110", k, {cpu_rdata_v, cpu_err, cpu_wack}); end
            checks++; if (cpu_rdata !== ((k == 0) ? 32'h55 : 32'h66)) begin errors++; $display("FAIL er_data%0d got %h want %h", k, cpu_rdata, (k == 0) ? 32'h55 : 32'h66); end
            tick();
            checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL er_clear%0d got %h want 0", k, cpu_err); end
        end
        tl.d_valid = 1'b1; tl.d_opcode = 4'h1; tl.d_data = 32'h99;
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({cpu_err, cpu_rdata_v, cpu_wack, cpu_rdata} !== {3'b100, 32'h66}) begin errors++; $display("FAIL er_spurious got %h want %h", {cpu_err, cpu_rdata_v, cpu_wack, cpu_rdata}, {3'b100, 32'h66}); end
        tick();
        checks++; if ({trans_over, cpu_err} !== 2'b10) begin errors++; $display("FAIL er_idle got %b want 10", {trans_over, cpu_err}); end
    endtask

    task automatic test_reset_mid();
        tl.a_ready = 1'b1; cpu_rd = 1'b1; cpu_byte = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            cpu_addr = 4'(i);
            tick();
        end
        cpu_rd = 1'b0;
        checks++; if ({tl.a_valid, trans_over, tl.a_address} !== {1'b0, 1'b0, 4'h3}) begin errors++; $display("FAIL rm_loaded got %h want %h", {tl.a_valid, trans_over, tl.a_address}, {1'b0, 1'b0, 4'h3}); end
        rst = 1'b1;
        tl.d_valid = 1'b1; tl.d_opcode = 4'h1; tl.d_data = 32'h77;
        tick();
        rst = 1'b0; tl.d_valid = 1'b0;
        checks++; if ({tl.a_valid, tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data, tl.d_ready} !== 46'h0) begin errors++; $display("FAIL rm_bus got %h want 0", {tl.a_valid, tl.a_opcode, tl.a_mask, tl.a_address, tl.a_data, tl.d_ready}); end
        checks++; if ({cpu_rdata_v, cpu_wack, cpu_err, cpu_rdata, cpu_ready, trans_over} !== {3'b000, 32'h0, 2'b11}) begin errors++; $display("FAIL rm_cpu got %h want %h", {cpu_rdata_v, cpu_wack, cpu_err, cpu_rdata, cpu_ready, trans_over}, {3'b000, 32'h0, 2'b11}); end
        tick();
        tl.d_valid = 1'b1;
        tick();
        tl.d_valid = 1'b0;
        checks++; if ({cpu_err, cpu_rdata_v, cpu_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rm_counter0 got %h want %h", {cpu_err, cpu_rdata_v, cpu_rdata}, {2'b10, 32'h0}); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_byte = 4'h0; cpu_addr = 4'h0; cpu_wdata = 32'h0;
        tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_opcode = 4'h0; tl.d_error = 1'b0; tl.d_data = 32'h0;
        tick();
        tick();
        test_reset();
        test_write_full();
        test_partial_read();
        test_stall();
        test_max_out();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_ul_master_q.md
# tl_ul_master_q

Parametrised TileLink-UL master bridging the CPU request port to the A/D channel pair of the on-chip bus. Replaces the single-transaction master: CPU requests are buffered in a request FIFO, A-channel beats are held until accepted, and up to MAX_OUT transactions may be outstanding, with in-order response routing back to the CPU (read data, write acks, errors).

## Interface
- AW, 4: address width.
- DW, 32: data width; multiple of 8, mask width MW = DW/8.
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- MAX_OUT, 2: maximum issued-but-unanswered transactions; 1..8.
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_wr / cpu_rd  in  1  request strobes, sampled when cpu_ready=1.
- cpu_byte  in  MW  byte enables.  cpu_addr  in  AW.  cpu_wdata  in  DW.
- cpu_ready  out  1  request FIFO not full.
- cpu_rdata_v  out  1  one-cycle pulse, read data valid.  cpu_rdata  out  DW.
- cpu_wack  out  1  one-cycle pulse, write acknowledged.
- cpu_err  out  1  one-cycle pulse, response error / protocol violation.
- a_valid out 1, a_ready in 1, a_opcode out 4, a_mask out MW, a_address out AW, a_data out DW.
- d_ready out 1, d_valid in 1, d_opcode in 4, d_error in 1, d_data in DW.
- trans_over  out  1  high when FIFO empty and nothing outstanding.

## Operation
- Accept: cpu_wr|cpu_rd with cpu_ready=1 pushes {opcode, mask, addr, wdata}. Both strobes high: write wins, read discarded. Strobes with cpu_ready=0 are ignored (CPU must hold).
- Opcode: write with all mask bits set → PutFullData (0); other writes, including mask 0 → PutPartialData (1); read → Get (4), a_data = 0.
- A channel driven from FIFO head: a_valid = ~empty & (outstanding < MAX_OUT). Once a_valid=1, a_* stable until a_valid&a_ready; pop on that handshake. a_* of an empty FIFO read as 0.
- Outstanding counter (width clog2(MAX_OUT+1)): +1 on A handshake, −1 on D handshake, unchanged when both same cycle. Pending-type FIFO (depth MAX_OUT, 1 bit is_read) pushed on A handshake, popped on D handshake.
- d_ready = 1 in every cycle after reset.
- D handshake with outstanding>0: pop type; read → cpu_rdata_v=1, cpu_rdata=d_data; write → cpu_wack=1. cpu_err=1 additionally if d_error=1 or d_opcode mismatches (AccessAckData 1 expected for reads, AccessAck 0 for writes); rdata_v/wack still pulse.
- D handshake with outstanding=0: counter and type FIFO untouched, cpu_err pulses, no rdata_v/wack.

## Timing
- Reset values: a_valid 0, a_opcode/a_mask/a_address/a_data 0, d_ready 0, cpu_rdata_v 0, cpu_rdata 0, cpu_wack 0, cpu_err 0, cpu_ready 1, trans_over 1; FIFOs empty, counter 0. Reset mid-transaction discards all queued and outstanding state.
- CPU accept at edge N → a_valid high from cycle N+1 (if outstanding < MAX_OUT).
- D handshake at edge M → cpu_rdata_v/cpu_wack/cpu_err high during cycle M+1 for exactly one cycle; cpu_rdata registered, holds last value otherwise.
- Push and pop same cycle when full: allowed only if pop occurs; cpu_ready is from registered state, so full FIFO stalls one cycle even if popped.
- Back-to-back A handshakes at one per cycle while FIFO non-empty and limit not reached.
- trans_over falls the cycle after the first accept; rises the cycle after the last D handshake empties everything.

## Structure
- Package tl_ul_pkg: A opcodes PUT_FULL=4'h0, PUT_PARTIAL=4'h1, GET=4'h4; D opcodes ACK=4'h0, ACK_DATA=4'h1; request-entry struct.
- One sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/head), instantiated twice: request FIFO and pending-type FIFO.

## Test plan
- Write addr 4'h3, byte 4'hF, data 32'hDEADBEEF, a_ready=1, d_valid with opcode 0 two cycles later → a_opcode 0, a_mask F, one cpu_wack pulse, trans_over back to 1.
- Write byte 4'h5 then read addr 4'h3 → opcodes 1 then 4; D returns ACK then ACK_DATA data 32'h12345678 → wack then cpu_rdata_v with 32'h12345678.
- a_ready low for 5 cycles with 3 queued requests → a_* stable throughout; cpu_ready drops after 4th accept (DEPTH=4).
- MAX_OUT=2, a_ready=1, no D response, 4 requests → exactly 2 A handshakes, a_valid 0 until first D handshake.
- Read answered with d_opcode 0 and separately with d_error=1 → cpu_rdata_v and cpu_err both pulse; spurious d_valid at idle → cpu_err only, counter stays 0.
- rst asserted with 2 outstanding, 2 queued → all outputs reset values next cycle, trans_over 1.
